// File: rtl/timer_irq_ctrl_if.sv
// Register-port bundle for timer_irq_ctrl: strobes, address, write data and registered read data.
// The master drives the bus; the slave (the timer) returns read data.
interface timer_irq_ctrl_if;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (
        output reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Machine timer with prescaler/compare and a confirm-pulse handshake into the fetch-stage PC register.
// Build option: define TIMER_AUTORELOAD_EN to make CTRL[2] (ARL) reset the count to 0 on a match.
module timer_irq_ctrl #(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    timer_irq_ctrl_if.slave        bus,
    input  logic                   global_ie,
    input  logic                   stall,
    input  logic [31:0]            resume_pc,
    input  logic                   mret,
    output logic                   Interrupt_Confirm_Timer,
    output logic [31:0]            mepc_out,
    output logic                   irq_pending
);
    // state        | meaning
    // S_IDLE       | no serviceable request (PEND clear or IEN off)
    // S_PENDING    | request waiting for global_ie and an unstalled cycle
    // S_IN_HANDLER | confirm delivered, re-entry blocked until mret
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PENDING    = 2'd1,
        S_IN_HANDLER = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_COMPARE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    state_t             state_q, state_d;
    logic               ten_q, ten_d;
    logic               ien_q, ien_d;
    logic               pend_q, pend_d;
    logic               arl;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]   compare_q, compare_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        rd_val;
    logic               tick, match, confirm;
    logic               wr_ctrl, wr_pre, wr_cmp, wr_cnt;

    assign wr_ctrl = bus.reg_wr_en && (bus.reg_addr == ADDR_CTRL);
    assign wr_pre  = bus.reg_wr_en && (bus.reg_addr == ADDR_PRESCALE);
    assign wr_cmp  = bus.reg_wr_en && (bus.reg_addr == ADDR_COMPARE);
    assign wr_cnt  = bus.reg_wr_en && (bus.reg_addr == ADDR_COUNT);

`ifdef TIMER_AUTORELOAD_EN
    logic arl_q, arl_d;

    always_comb begin
        arl_d = arl_q;
        if (wr_ctrl) arl_d = bus.reg_wdata[2];
    end

    always_ff @(posedge clk) begin
        if (rst) arl_q <= 1'b0;
        else     arl_q <= arl_d;
    end

    assign arl = arl_q;
`else
    assign arl = 1'b0;
`endif

    assign tick  = ten_q && (pre_cnt_q == prescale_q);
    assign match = tick && (count_q == compare_q);

    // A COUNT write overrides the tick update, but the match above still sees the old count.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        count_d   = count_q;
        if (ten_q) pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        if (tick) begin
            if (match && arl) count_d = '0;
            else              count_d = count_q + CNT_W'(1);
        end
        if (wr_cnt) begin
            count_d   = bus.reg_wdata[CNT_W-1:0];
            pre_cnt_d = '0;
        end
    end

    always_comb begin
        ten_d      = ten_q;
        ien_d      = ien_q;
        pend_d     = pend_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        if (wr_ctrl) begin
            ten_d = bus.reg_wdata[0];
            ien_d = bus.reg_wdata[1];
            if (bus.reg_wdata[8]) pend_d = 1'b0;
        end
        if (wr_pre) prescale_d = bus.reg_wdata[PRE_W-1:0];
        if (wr_cmp) compare_d  = bus.reg_wdata[CNT_W-1:0];
        if (match)  pend_d     = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (bus.reg_addr)
            ADDR_CTRL:     rd_val = {23'd0, pend_q, 5'd0, arl, ien_q, ten_q};
            ADDR_PRESCALE: rd_val = 32'(prescale_q);
            ADDR_COMPARE:  rd_val = 32'(compare_q);
            default:       rd_val = 32'(count_q);
        endcase
        rdata_d = bus.reg_rd_en ? rd_val : rdata_q;
    end

    always_comb begin
        state_d = state_q;
        mepc_d  = mepc_q;
        confirm = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q && ien_q) state_d = S_PENDING;
            end
            S_PENDING: begin
                confirm = global_ie && ien_q && !stall && !rst;
                if (confirm) begin
                    mepc_d  = resume_pc;
                    state_d = S_IN_HANDLER;
                end else if (!pend_q || !ien_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IN_HANDLER: begin
                if (mret) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ten_q      <= 1'b0;
            ien_q      <= 1'b0;
            pend_q     <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            rdata_q    <= '0;
            mepc_q     <= '0;
        end else begin
            state_q    <= state_d;
            ten_q      <= ten_d;
            ien_q      <= ien_d;
            pend_q     <= pend_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            rdata_q    <= rdata_d;
            mepc_q     <= mepc_d;
        end
    end

    assign Interrupt_Confirm_Timer = confirm;
    assign mepc_out                = mepc_q;
    assign irq_pending             = pend_q;
    assign bus.reg_rdata           = rdata_q;
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: register read/write vector table plus hand-built irq sequences.
`timescale 1ns/1ps
module tb_timer_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        global_ie, stall, mret;
    logic [31:0] resume_pc, mepc_out;
    logic        irq_confirm, irq_pending;
    int          n_checks = 0;
    int          n_fail   = 0;

    timer_irq_ctrl_if bus();

    timer_irq_ctrl #(.CNT_W(32), .PRE_W(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus                     (bus),
        .global_ie               (global_ie),
        .stall                   (stall),
        .resume_pc               (resume_pc),
        .mret                    (mret),
        .Interrupt_Confirm_Timer (irq_confirm),
        .mepc_out                (mepc_out),
        .irq_pending             (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    localparam logic [1:0] A_CTRL = 2'd0, A_PRE = 2'd1, A_CMP = 2'd2, A_CNT = 2'd3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        bus.reg_wr_en = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        step();
        bus.reg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        bus.reg_rd_en = 1'b1;
        bus.reg_addr  = a;
        step();
        bus.reg_rd_en = 1'b0;
        d = bus.reg_rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.reg_wr_en = 1'b0;
        bus.reg_rd_en = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 32'd0;
        global_ie = 1'b0;
        stall     = 1'b0;
        mret      = 1'b0;
        resume_pc = 32'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Cycle k: inputs for the cycle are driven just after edge k, outputs observed 1 time unit later.
    task automatic run_irq(input int stall_from, input int stall_to, input int n,
                           output int pend_at, output int conf_at, output int conf_cnt,
                           output int conf_in_stall);
        pend_at = -1;
        conf_at = -1;
        conf_cnt = 0;
        conf_in_stall = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            stall     = (k >= stall_from) && (k < stall_to);
            resume_pc = 32'h0000_4000 + 32'(k) * 32'd4;
            #1;
            if (irq_pending && pend_at < 0) pend_at = k;
            if (irq_confirm) begin
                conf_cnt++;
                if (conf_at < 0) conf_at = k;
                if (stall) conf_in_stall++;
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] rd;
        int          pend_at, conf_at, conf_cnt, conf_in_stall, nconf;
        int          first_pend, second_pend;
        logic [31:0] cnt_after_match, ctrl_rd;

        vecs[0] = '{A_PRE,  32'h0000_005A, 32'h0000_005A, "prescale_5a"};
        vecs[1] = '{A_PRE,  32'hFFFF_FF03, 32'h0000_0003, "prescale_trunc"};
        vecs[2] = '{A_CMP,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "compare_full"};
        vecs[3] = '{A_CMP,  32'h0000_0000, 32'h0000_0000, "compare_zero"};
        vecs[4] = '{A_CNT,  32'h1234_5678, 32'h1234_5678, "count_load"};
        vecs[5] = '{A_CTRL, 32'h0000_0002, 32'h0000_0002, "ctrl_ien"};
`ifdef TIMER_AUTORELOAD_EN
        vecs[6] = '{A_CTRL, 32'hFFFF_FEF6, 32'h0000_0006, "ctrl_masked"};
`else
        vecs[6] = '{A_CTRL, 32'hFFFF_FEF6, 32'h0000_0002, "ctrl_masked"};
`endif
        vecs[7] = '{A_CTRL, 32'h0000_0000, 32'h0000_0000, "ctrl_clear"};

        // Reset and idle
        do_reset();
        nconf = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq_confirm) nconf++;
        end
        check("reset_idle_confirms", 32'(nconf), 32'd0);
        check("reset_rdata", bus.reg_rdata, 32'd0);
        check("reset_pending", {31'd0, irq_pending}, 32'd0);
        check("reset_mepc", mepc_out, 32'd0);

        // Register write/readback table, with timer stopped
        foreach (vecs[i]) begin
            reg_write(vecs[i].addr, vecs[i].wdata);
            reg_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
            step();
            check({vecs[i].name, "_hold"}, bus.reg_rdata, vecs[i].exp);
        end

        // Basic match -> pend at 6th tick edge, confirm one cycle after FSM enters PENDING
        do_reset();
        global_ie = 1'b1;
        reg_write(A_PRE, 32'd0);
        reg_write(A_CMP, 32'd5);
        reg_write(A_CTRL, 32'h3);
        run_irq(0, 0, 15, pend_at, conf_at, conf_cnt, conf_in_stall);
        check("basic_pend_cycle", 32'(pend_at), 32'd6);
        check("basic_confirm_cycle", 32'(conf_at), 32'd7);
        check("basic_confirm_count", 32'(conf_cnt), 32'd1);
        check("basic_mepc", mepc_out, 32'h0000_401C);

        // Same but stalled for 4 cycles where the confirm would have fired
        do_reset();
        global_ie = 1'b1;
        reg_write(A_PRE, 32'd0);
        reg_write(A_CMP, 32'd5);
        reg_write(A_CTRL, 32'h3);
        run_irq(7, 11, 16, pend_at, conf_at, conf_cnt, conf_in_stall);
        check("stall_pend_cycle", 32'(pend_at), 32'd6);
        check("stall_confirm_cycle", 32'(conf_at), 32'd11);
        check("stall_confirm_count", 32'(conf_cnt), 32'd1);
        check("stall_confirm_while_stalled", 32'(conf_in_stall), 32'd0);
        check("stall_mepc", mepc_out, 32'h0000_402C);

        // In handler with PEND still set and a second match: no re-entry until mret
        reg_write(A_CNT, 32'd2);
        run_irq(0, 0, 10, pend_at, conf_at, conf_cnt, conf_in_stall);
        check("handler_no_confirm", 32'(conf_cnt), 32'd0);
        check("handler_pend_held", {31'd0, irq_pending}, 32'd1);
        mret = 1'b1;
        step();
        mret = 1'b0;
        #1;
        check("mret_idle_no_confirm", {31'd0, irq_confirm}, 32'd0);
        run_irq(0, 0, 5, pend_at, conf_at, conf_cnt, conf_in_stall);
        check("reentry_confirm_cycle", 32'(conf_at), 32'd1);
        check("reentry_confirm_count", 32'(conf_cnt), 32'd1);
        check("reentry_mepc", mepc_out, 32'h0000_4004);

        // Reset while in the handler
        rst = 1'b1;
        step();
        check("rst_mid_confirm", {31'd0, irq_confirm}, 32'd0);
        check("rst_mid_pending", {31'd0, irq_pending}, 32'd0);
        check("rst_mid_mepc", mepc_out, 32'd0);
        rst = 1'b0;
        global_ie = 1'b1;
        run_irq(0, 0, 6, pend_at, conf_at, conf_cnt, conf_in_stall);
        check("rst_mid_after_confirms", 32'(conf_cnt), 32'd0);

        // W1C of PEND colliding with a match: set wins
        do_reset();
        reg_write(A_PRE, 32'd0);
        reg_write(A_CMP, 32'd5);
        reg_write(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) step();
        reg_write(A_CTRL, 32'h101);
        check("w1c_vs_match_pend", {31'd0, irq_pending}, 32'd1);
        reg_write(A_CTRL, 32'h101);
        check("w1c_clears_pend", {31'd0, irq_pending}, 32'd0);

        // COUNT write on a matching tick: pend from old count, new count loaded
        reg_write(A_CTRL, 32'h0);
        reg_write(A_CNT, 32'd5);
        reg_write(A_CTRL, 32'h1);
        reg_write(A_CNT, 32'h100);
        check("cntwr_match_pend", {31'd0, irq_pending}, 32'd1);
        reg_read(A_CNT, rd);
        check("cntwr_beats_tick", rd, 32'h100);

        // Auto-reload build option: PRESCALE=1, COMPARE=3, CTRL=0x7
        do_reset();
        reg_write(A_PRE, 32'd1);
        reg_write(A_CMP, 32'd3);
        reg_write(A_CTRL, 32'h7);
        reg_read(A_CTRL, ctrl_rd);
        first_pend = -1;
        second_pend = -1;
        cnt_after_match = 32'hFFFF_FFFF;
        for (int k = 2; k <= 18; k++) begin
            bus.reg_rd_en = (k == 9);
            bus.reg_wr_en = (k == 10);
            bus.reg_addr  = (k == 9) ? A_CNT : A_CTRL;
            bus.reg_wdata = 32'h107;
            step();
            bus.reg_rd_en = 1'b0;
            bus.reg_wr_en = 1'b0;
            if (k == 9) cnt_after_match = bus.reg_rdata;
            if (irq_pending && first_pend < 0) first_pend = k;
            if (irq_pending && k > 10 && second_pend < 0) second_pend = k;
        end
        check("arl_first_pend", 32'(first_pend), 32'd8);
`ifdef TIMER_AUTORELOAD_EN
        check("arl_ctrl_read", ctrl_rd, 32'h7);
        check("arl_count_after_match", cnt_after_match, 32'd0);
        check("arl_second_pend", 32'(second_pend), 32'd16);
`else
        check("noarl_ctrl_read", ctrl_rd, 32'h3);
        check("noarl_count_after_match", cnt_after_match, 32'd4);
        check("noarl_no_second_pend", 32'(second_pend), 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Machine-timer and interrupt-request controller that drives `Interrupt_Confirm_Timer` into the fetch-stage PC register. It holds a prescaled counter with a compare register programmed over a simple register port. It tracks the pending flag and hands exactly one confirm pulse to the core when interrupts are enabled and the pipeline is not stalled. It saves the resume PC and blocks re-entry until the core signals `mret`.

## Interface

Parameters:
- `CNT_W`, default 32: counter and compare width (≤32).
- `PRE_W`, default 8: prescaler width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `reg_wr_en`  in  1  register write strobe.
- `reg_rd_en`  in  1  register read strobe.
- `reg_addr`  in  2  0=CTRL, 1=PRESCALE, 2=COMPARE, 3=COUNT.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, registered.
- `global_ie`  in  1  core global interrupt enable (mstatus.MIE).
- `stall`  in  1  same stall that holds the PC register.
- `resume_pc`  in  32  PC to return to if the interrupt is taken this cycle.
- `mret`  in  1  single-cycle pulse: handler return retired.
- `Interrupt_Confirm_Timer`  out  1  one-cycle take-interrupt pulse to the PC register.
- `mepc_out`  out  32  captured resume PC.
- `irq_pending`  out  1  pending flag (CTRL[8]).

## Operation

- CTRL bits:
  - [0] `TEN`: timer run.
  - [1] `IEN`: irq enable.
  - [2] `ARL`: auto-reload (see Configuration).
  - [8] `PEND`: read; write 1 clears.
  - Other bits read 0.
- Prescaler: when `TEN`=1, `pre_cnt` increments each cycle. When `pre_cnt`==PRESCALE, `pre_cnt`<=0 and `tick`=1. PRESCALE=0 gives a tick every cycle.
- Counter on `tick`:
  - If `count`==COMPARE: set `PEND`; `count`<=0 if `ARL`, else `count`+1.
  - Otherwise `count`+1.
  - Arithmetic is mod 2^CNT_W; wrap from all-ones to 0 is silent.
- COUNT write loads `count` and clears `pre_cnt`. A COUNT write beats a same-cycle tick. Match check uses the pre-write value.
- COMPARE write takes effect next cycle. A same-cycle match uses the old COMPARE.
- `PEND` set and write-1-clear in the same cycle: set wins, `PEND` stays 1.
- FSM states and transitions:
  - IDLE → PENDING when `PEND` && `IEN`.
  - PENDING:
    - `Interrupt_Confirm_Timer` = `global_ie` && `IEN` && !`stall` (combinational from registered state).
    - On confirm: `mepc_out`<=`resume_pc`, go to IN_HANDLER.
    - If `PEND` or `IEN` drops, return to IDLE.
  - IN_HANDLER: no confirm. On `mret` go to IDLE; a still-set `PEND` re-enters PENDING the following cycle.
- `mret` outside IN_HANDLER is ignored.
- Reads return the register value as of the read cycle, in `reg_rdata` on the next cycle; otherwise `reg_rdata` holds.

## Timing

- Reset values: all registers, `count`, `pre_cnt`, `mepc_out`, and `reg_rdata` are 0. `Interrupt_Confirm_Timer`=0, `irq_pending`=0, FSM=IDLE.
- Reset mid-handler drops to IDLE with no confirm.
- Match latency:
  - Edge E: tick with match sets `PEND`.
  - Edge E+1: FSM enters PENDING.
  - Cycle after E+1: confirm is high if `global_ie`, `IEN` and !`stall`.
- Confirm is exactly 1 cycle wide and never asserted while `stall`=1. While stalled it is delayed, not dropped.
- At most one confirm per `mret`.
- Register read latency is 1 cycle. Write latency is 1 cycle.

## Configuration

- `TIMER_AUTORELOAD_EN` defined: CTRL[2] is writable and readable; on match with `ARL`=1, `count`<=0.
- Not defined:
  - CTRL[2] is hardwired 0 and writes are ignored.
  - The counter always free-runs through the match and wraps mod 2^CNT_W.
  - No reload logic is synthesised.

## Test plan

- Reset then idle 20 cycles → `Interrupt_Confirm_Timer`=0, `reg_rdata`=0, `irq_pending`=0.
- PRESCALE=0, COMPARE=5, CTRL=0x3, `global_ie`=1 → `PEND` set at the 6th tick edge; confirm high for 1 cycle 2 cycles later; `mepc_out`=`resume_pc` sampled that cycle.
- As above with `stall`=1 for 4 cycles at the pending point → confirm held off, then a single pulse the first cycle `stall`=0.
- In IN_HANDLER, `PEND` left set and a second match occurs → no confirm until `mret`; PENDING one cycle after `mret`, confirm on the next cycle.
- W1C of CTRL[8] in the same cycle as a match → `irq_pending` remains 1.
- With `TIMER_AUTORELOAD_EN` defined, CTRL=0x7, COMPARE=3, PRESCALE=1 → COUNT reads 0 after each match and `PEND` sets every 8 cycles. Without the macro, CTRL reads 0x3 and COUNT reads 4 after the match.
